// File: rtl/rv_fetch_buf.sv
// Instruction fetch buffer between I_MEM response (Q101H) and decode (Q102H).
// Small FIFO of {instr, pc} pairs; a redirect flush drops everything buffered and in flight.
module rv_fetch_buf #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_Q101H,
   input  logic [31:0] instr_Q101H,
   input  logic [31:0] pc_Q101H,
   input  logic        flush_Q102H,
   input  logic        dec_ready_Q102H,
   output logic        ready_Q101H,
   output logic        valid_Q102H,
   output logic [31:0] instr_Q102H,
   output logic [31:0] pc_Q102H
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [31:0] Nop = 32'h0000_0013;

   logic [DEPTH-1:0][31:0] instr_q, instr_d;
   logic [DEPTH-1:0][31:0] pc_q, pc_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   push, pop;

   // Ready depends on state only, so a pop cannot make room in the same cycle.
   assign ready_Q101H = (count_q < CntW'(DEPTH));
   assign valid_Q102H = (count_q != '0);
   assign instr_Q102H = valid_Q102H ? instr_q[rd_ptr_q] : Nop;
   assign pc_Q102H    = valid_Q102H ? pc_q[rd_ptr_q] : 32'h0;

   assign push = valid_Q101H & ready_Q101H & ~flush_Q102H;
   assign pop  = valid_Q102H & dec_ready_Q102H & ~flush_Q102H;

   always_comb begin
      instr_d  = instr_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_Q102H) begin
         // Storage is left alone; it is unreachable once count is zero.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = instr_Q101H;
            pc_d[wr_ptr_q]    = pc_Q101H;
            wr_ptr_d          = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q  <= '0;
         pc_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_rv_fetch_buf.sv
// Bench for rv_fetch_buf: per-cycle vector table, hand-written reset sequence and a
// queue-scoreboarded random stall run across pointer wrap.
module tb_rv_fetch_buf;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_Q101H = 1'b0;
   logic [31:0] instr_Q101H = '0;
   logic [31:0] pc_Q101H = '0;
   logic        flush_Q102H = 1'b0;
   logic        dec_ready_Q102H = 1'b0;
   logic        ready_Q101H;
   logic        valid_Q102H;
   logic [31:0] instr_Q102H;
   logic [31:0] pc_Q102H;

   int n_chk = 0;
   int n_fail = 0;

   rv_fetch_buf #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_Q101H     (valid_Q101H),
      .instr_Q101H     (instr_Q101H),
      .pc_Q101H        (pc_Q101H),
      .flush_Q102H     (flush_Q102H),
      .dec_ready_Q102H (dec_ready_Q102H),
      .ready_Q101H     (ready_Q101H),
      .valid_Q102H     (valid_Q102H),
      .instr_Q102H     (instr_Q102H),
      .pc_Q102H        (pc_Q102H)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        fl;
      logic        dr;
      logic        ev;
      logic        er;
      logic [31:0] epc;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   vec_t vecs[18];
   ent_t sb[$];

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return {pc[19:0], 12'h0b3} ^ 32'h5a00_0000;
   endfunction

   function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic fl,
                                input logic dr, input logic ev, input logic er,
                                input logic [31:0] epc);
      vec_t r;
      r.v = v; r.pc = pc; r.fl = fl; r.dr = dr; r.ev = ev; r.er = er; r.epc = epc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic er,
                          input logic [31:0] epc, input logic [31:0] einstr);
      chk({tag, ".valid"}, {31'b0, valid_Q102H}, {31'b0, ev});
      chk({tag, ".ready"}, {31'b0, ready_Q101H}, {31'b0, er});
      chk({tag, ".pc"}, pc_Q102H, epc);
      chk({tag, ".instr"}, instr_Q102H, einstr);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic dr);
      valid_Q101H     = v;
      pc_Q101H        = pc;
      instr_Q101H     = mk_instr(pc);
      flush_Q102H     = fl;
      dec_ready_Q102H = dr;
   endtask

   initial begin
      //                v  pc          fl dr  ev er epc
      vecs[0]  = mkv(1, 32'h000, 0, 1,  0, 1, 32'h000);
      vecs[1]  = mkv(1, 32'h004, 0, 1,  1, 1, 32'h000);
      vecs[2]  = mkv(1, 32'h008, 0, 1,  1, 1, 32'h004);
      vecs[3]  = mkv(1, 32'h00c, 0, 1,  1, 1, 32'h008);
      vecs[4]  = mkv(0, 32'h000, 0, 1,  1, 1, 32'h00c);
      vecs[5]  = mkv(0, 32'h000, 0, 1,  0, 1, 32'h000);
      vecs[6]  = mkv(1, 32'h100, 0, 0,  0, 1, 32'h000);
      vecs[7]  = mkv(1, 32'h104, 0, 0,  1, 1, 32'h100);
      vecs[8]  = mkv(1, 32'h108, 0, 0,  1, 0, 32'h100);
      vecs[9]  = mkv(0, 32'h000, 0, 1,  1, 0, 32'h100);
      vecs[10] = mkv(1, 32'h110, 0, 0,  1, 1, 32'h104);
      vecs[11] = mkv(1, 32'h114, 0, 1,  1, 0, 32'h104);
      vecs[12] = mkv(1, 32'h118, 0, 0,  1, 1, 32'h110);
      vecs[13] = mkv(1, 32'h11c, 1, 1,  1, 0, 32'h110);
      vecs[14] = mkv(0, 32'h000, 0, 0,  0, 1, 32'h000);
      vecs[15] = mkv(1, 32'h200, 0, 0,  0, 1, 32'h000);
      vecs[16] = mkv(0, 32'h000, 0, 1,  1, 1, 32'h200);
      vecs[17] = mkv(0, 32'h000, 0, 0,  0, 1, 32'h000);

      #3;
      chk_out("reset", 1'b0, 1'b1, 32'h0, 32'h13);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven: outputs checked before the edge that applies the row's inputs.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].epc,
                 vecs[i].ev ? mk_instr(vecs[i].epc) : 32'h13);
         drive(vecs[i].v, vecs[i].pc, vecs[i].fl, vecs[i].dr);
      end

      // Random stalls across many pointer wraps, scoreboarded.
      sb.delete();
      for (int c = 0; c < 60; c++) begin
         logic v, dr, do_push, do_pop;
         logic [31:0] pc;
         ent_t e;
         @(negedge clk);
         if (sb.size() != 0) begin
            chk_out($sformatf("rnd%0d", c), 1'b1, sb.size() < DEPTH, sb[0].pc, sb[0].instr);
         end else begin
            chk_out($sformatf("rnd%0d", c), 1'b0, 1'b1, 32'h0, 32'h13);
         end
         v  = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 2) != 0);
         pc = 32'h1000 + 32'(c * 4);
         do_push = v && (sb.size() < DEPTH);
         do_pop  = dr && (sb.size() != 0);
         drive(v, pc, 1'b0, dr);
         if (do_pop) void'(sb.pop_front());
         if (do_push) begin
            e.pc = pc;
            e.instr = mk_instr(pc);
            sb.push_back(e);
         end
      end
      for (int c = 0; c < 8 && sb.size() != 0; c++) begin
         @(negedge clk);
         chk_out($sformatf("drain%0d", c), 1'b1, sb.size() < DEPTH, sb[0].pc, sb[0].instr);
         drive(1'b0, 32'h0, 1'b0, 1'b1);
         void'(sb.pop_front());
      end
      @(negedge clk);
      chk_out("drained", 1'b0, 1'b1, 32'h0, 32'h13);

      // Mid-stream asynchronous reset with two entries buffered.
      drive(1'b1, 32'h400, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h404, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("pre_rst", 1'b1, 1'b0, 32'h400, mk_instr(32'h400));
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, 1'b1, 32'h0, 32'h13);
      @(negedge clk);
      chk_out("rst_held", 1'b0, 1'b1, 32'h0, 32'h13);
      rst = 1'b1;
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      @(negedge clk);
      chk_out("post_rst_push", 1'b1, 1'b1, 32'h300, mk_instr(32'h300));
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      chk_out("post_rst_pop", 1'b0, 1'b1, 32'h0, 32'h13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_fetch_buf.md
# rv_fetch_buf

Instruction fetch buffer between the I_MEM response (Q101H) and decode (Q102H). It captures each fetched instruction with its PC in a small FIFO. It holds that pair until decode accepts it, and drives back-pressure to the fetch stage. It drops all buffered and in-flight instructions when a redirect (taken branch/jump) resolves, so decode never sees wrong-path instructions.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously with clk).
- valid_Q101H  input  1  I_MEM returns a valid instruction this cycle.
- instr_Q101H  input  32  instruction word from I_MEM.
- pc_Q101H  input  32  PC of instr_Q101H.
- flush_Q102H  input  1  redirect resolved (same condition that selects alu_out as next PC); kill all buffered and incoming instructions.
- dec_ready_Q102H  input  1  decode accepts the head entry this cycle.
- ready_Q101H  output  1  buffer can accept an instruction; feeds fetch-stage enables.
- valid_Q102H  output  1  head entry valid.
- instr_Q102H  output  32  head instruction; 32'h0000_0013 (NOP) when empty.
- pc_Q102H  output  32  head PC; 32'h0 when empty.

## Operation
- State: DEPTH x 64-bit storage (instr, pc), write pointer wr_ptr, read pointer rd_ptr (each log2(DEPTH) bits, wrap modulo DEPTH), occupancy count (log2(DEPTH)+1 bits, range 0..DEPTH).
- ready_Q101H = (count < DEPTH). It is a function of state only. There is no combinational path from dec_ready_Q102H or flush_Q102H.
- valid_Q102H = (count != 0). instr/pc outputs come from entry rd_ptr when valid, otherwise NOP/0.
- push = valid_Q101H & ready_Q101H & ~flush_Q102H. It writes {instr, pc} to entry wr_ptr and increments wr_ptr.
- pop = valid_Q102H & dec_ready_Q102H & ~flush_Q102H. It increments rd_ptr.
- count next: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: while count == DEPTH, ready_Q101H = 0 even if a pop occurs the same cycle (no full-bypass). ready rises the cycle after the pop.
- Empty: no bypass from Q101H to Q102H. An instruction pushed while empty appears the next cycle.
- flush_Q102H = 1 sets count, wr_ptr and rd_ptr to 0 next cycle. The incoming instruction that cycle is dropped, and no pop is counted. Storage contents are left unchanged (don't-care once count is 0).
- flush has priority over push and pop in every cycle.
- Pointer wrap: after entry DEPTH-1, the pointer returns to 0. Ordering stays strict FIFO across the wrap.
- Reset (rst low, any time including mid-operation): count = 0, pointers = 0, storage = 0. Outputs go immediately to valid_Q102H = 0, ready_Q101H = 1, instr_Q102H = 32'h0000_0013, pc_Q102H = 0.

## Timing
- Latency: instruction pushed in cycle N is presented on Q102H outputs in cycle N+1 at the earliest.
- Throughput: 1 instruction/cycle sustained while dec_ready_Q102H = 1 and not full.
- dec_ready_Q102H low holds the head stable (instr, pc, valid) every cycle until popped or flushed.
- After flush in cycle N: valid_Q102H = 0 in cycle N+1, ready_Q101H = 1 in cycle N+1. The first post-redirect instruction can be pushed in N+1 and appears in N+2.
- Outputs are glitch-free relative to clk: all derived from registers plus the storage read mux.

## Test plan
- Reset: hold rst low mid-stream with count = 2 -> outputs immediately valid = 0, ready = 1, instr = 32'h13, pc = 0; after release the first push appears one cycle later.
- Streaming: push pc 0x0,0x4,0x8,0xC back-to-back with dec_ready = 1 -> Q102H shows the same sequence one cycle delayed, valid continuous, ready never drops.
- Back-pressure: dec_ready = 0, push 0x100, 0x104 -> count = 2, ready = 0. A third valid input 0x108 is not accepted. Head stays 0x100. One dec_ready pulse -> head 0x104, ready = 1 the cycle after.
- Full plus pop: at count = 2, pop and valid input in the same cycle -> input not taken, count = 1.
- Flush: with 2 buffered plus a valid input, assert flush_Q102H for one cycle -> next cycle valid = 0, ready = 1. Push 0x200 next -> Q102H shows 0x200, no stale entries.
- Wrap: ten push/pop cycles with random dec_ready stalls -> output order matches input order exactly, and count never exceeds DEPTH.
